// File: rtl/branch_resolve_ctrl.sv
// Gshare branch predictor sequencer: forms the table index and issues predictions.
// It also tracks in-flight branches and writes back counters on resolution, with flush and GHR repair.
module branch_resolve_ctrl #(
  parameter int DEPTH  = 4,
  parameter int HIST_W = 8,
  parameter int PC_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      request,
  input  logic [PC_W-1:0]           pc,
  output logic                      req_ready,
  output logic                      pred_valid,
  output logic                      prediction,
  input  logic                      result,
  input  logic                      taken,
  output logic                      mispredict,
  output logic [HIST_W-1:0]         tbl_rd_idx,
  input  logic [1:0]                tbl_rd_data,
  output logic                      tbl_wr_en,
  output logic [HIST_W-1:0]         tbl_wr_idx,
  output logic [1:0]                tbl_wr_data,
  output logic [HIST_W-1:0]         ghr,
  output logic [$clog2(DEPTH):0]    inflight,
  output logic                      underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [HIST_W-1:0] r_fifo_idx  [DEPTH];
  logic [1:0]        r_fifo_ctr  [DEPTH];
  logic [HIST_W-2:0] r_fifo_hist [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [HIST_W-1:0] r_ghr;
  logic              r_pred_valid, r_prediction, r_mispredict, r_underflow;
  logic              r_wr_en;
  logic [HIST_W-1:0] r_wr_idx;
  logic [1:0]        r_wr_data;

  logic [HIST_W-1:0] w_rd_idx;
  logic              w_ready;
  logic [1:0]        w_eff_ctr;
  logic [1:0]        w_head_ctr;
  logic [HIST_W-1:0] w_head_idx;
  logic [HIST_W-2:0] w_head_hist;
  logic              w_resolve, w_mis, w_push;
  logic [1:0]        w_upd_ctr;

  if (PC_W > HIST_W) begin : g_pc_hi
    logic w_unused_pc_hi;
    assign w_unused_pc_hi = ^pc[PC_W-1:HIST_W];
  end

  assign w_rd_idx    = pc[HIST_W-1:0] ^ r_ghr;
  assign w_ready     = (r_count != FULL);
  // A write landing this cycle on the index being looked up supersedes the stale table data.
  assign w_eff_ctr   = (r_wr_en && (r_wr_idx == w_rd_idx)) ? r_wr_data : tbl_rd_data;
  assign w_head_ctr  = r_fifo_ctr[r_rd_ptr];
  assign w_head_idx  = r_fifo_idx[r_rd_ptr];
  assign w_head_hist = r_fifo_hist[r_rd_ptr];
  assign w_resolve   = result && (r_count != '0);
  assign w_mis       = w_resolve && (taken != w_head_ctr[1]);
  assign w_push      = request && w_ready && !w_mis;

  always_comb begin
    w_upd_ctr = w_head_ctr;
    if (taken) begin
      if (w_head_ctr != 2'd3) w_upd_ctr = w_head_ctr + 2'd1;
    end else begin
      if (w_head_ctr != 2'd0) w_upd_ctr = w_head_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr]  <= w_rd_idx;
      r_fifo_ctr[r_wr_ptr]  <= w_eff_ctr;
      r_fifo_hist[r_wr_ptr] <= r_ghr[HIST_W-2:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ghr        <= '0;
      r_pred_valid <= 1'b0;
      r_prediction <= 1'b0;
      r_mispredict <= 1'b0;
      r_underflow  <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_idx     <= '0;
      r_wr_data    <= '0;
    end else begin
      r_pred_valid <= w_push;
      r_prediction <= w_push ? w_eff_ctr[1] : 1'b0;
      r_mispredict <= w_mis;
      r_wr_en      <= w_resolve;
      if (w_resolve) begin
        r_wr_idx  <= w_head_idx;
        r_wr_data <= w_upd_ctr;
      end
      if (result && (r_count == '0)) r_underflow <= 1'b1;

      // A mispredict squashes every entry, so both pointers simply restart from zero.
      if (w_mis) begin
        r_ghr    <= {w_head_hist, taken};
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_ghr    <= {r_ghr[HIST_W-2:0], w_eff_ctr[1]};
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_resolve) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_resolve)      r_count <= r_count + 1'b1;
        else if (!w_push && w_resolve) r_count <= r_count - 1'b1;
      end
    end
  end

  assign req_ready   = w_ready;
  assign tbl_rd_idx  = w_rd_idx;
  assign pred_valid  = r_pred_valid;
  assign prediction  = r_prediction;
  assign mispredict  = r_mispredict;
  assign tbl_wr_en   = r_wr_en;
  assign tbl_wr_idx  = r_wr_idx;
  assign tbl_wr_data = r_wr_data;
  assign ghr         = r_ghr;
  assign inflight    = r_count;
  assign underflow   = r_underflow;

endmodule
